// File: rtl/instr_loader_4core_if.sv
// Loader stream input (valid/ready) and instruction RAM write port.
// The loader sits on the slave side; the stream source and RAM on the master side.
interface instr_loader_4core_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader_4core.sv
// Program loader for the 4-core 1-bit array: length-prefixed, checksummed word
// stream into instruction RAM, then core preset and program-counter release.
module instr_loader_4core #(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned PRESET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instr_loader_4core_if.slave  bus,
  output logic                 cores_reset,
  output logic                 cores_preset,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PC_W  = $clog2(PRESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_PRESET, S_RUN, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [15:0]       sum_q, sum_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_d, done_d, err_d, cores_reset_d, cores_preset_d;
  logic              in_ready_c;
  logic              hs_c;

  // in_ready is decoded straight from the registered state
  assign in_ready_c    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign hs_c          = bus.in_valid & in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    pcnt_d      = pcnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN: begin
        if (hs_c) begin
          if ((bus.in_data != 16'd0) && (32'(bus.in_data) <= DEPTH)) begin
            len_d   = CNT_W'(bus.in_data);
            state_d = S_DATA;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DATA: begin
        if (hs_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(idx_q);
          mem_wdata_d = bus.in_data;
          sum_d       = sum_q + bus.in_data;
          idx_d       = idx_q + CNT_W'(1);
          if ((idx_q + CNT_W'(1)) == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (hs_c) begin
          pcnt_d  = '0;
          state_d = (bus.in_data == sum_q) ? S_PRESET : S_ERROR;
        end
      end
      S_PRESET: begin
        if (pcnt_q == PC_W'(PRESET_CYCLES - 1)) state_d = S_RUN;
        else                                    pcnt_d  = pcnt_q + PC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they change with it
    busy_d         = (state_d == S_LEN) || (state_d == S_DATA) ||
                     (state_d == S_CSUM) || (state_d == S_PRESET);
    done_d         = (state_d == S_RUN);
    err_d          = (state_d == S_ERROR);
    cores_reset_d  = (state_d != S_RUN);
    cores_preset_d = (state_d == S_PRESET);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      pcnt_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cores_reset  <= 1'b1;
      cores_preset <= 1'b0;
    end else begin
      len_q        <= len_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      pcnt_q       <= pcnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      cores_reset  <= cores_reset_d;
      cores_preset <= cores_preset_d;
    end
  end

endmodule

// File: tb/tb_instr_loader_4core.sv
// Self-checking bench for instr_loader_4core: directed and random load sessions
// compared against a stream-level model of the expected writes and outcome.
module tb_instr_loader_4core;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned P      = 2;

  logic clk = 1'b0;
  logic reset, start;
  logic cores_reset, cores_preset, busy, done, err;

  instr_loader_4core_if #(.ADDR_W(ADDR_W)) bus();

  always #5 clk = ~clk;

  instr_loader_4core #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRESET_CYCLES(P)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cores_reset(cores_reset), .cores_preset(cores_preset),
    .busy(busy), .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] stream[$];
  logic [15:0] m_wdata[$];
  int          m_consumed;
  bit          m_ok;

  // Expected behaviour from the stream alone: which words get written, how many
  // words are consumed, and whether the session should end running.
  function automatic void model();
    int l;
    int sum;
    l = int'(stream[0]);
    sum = 0;
    m_wdata.delete();
    if (l < 1 || l > int'(DEPTH)) begin
      m_consumed = 1;
      m_ok = 1'b0;
      return;
    end
    for (int i = 1; i <= l; i++) begin
      m_wdata.push_back(stream[i]);
      sum = (sum + int'(stream[i])) % 65536;
    end
    m_consumed = l + 2;
    m_ok = (int'(stream[l + 1]) == sum);
  endfunction

  // mode: 0 = valid always high, 1 = valid toggles, 2 = random valid
  task automatic run_session(input int mode, input int start_at, input string name);
    int pos;
    int cyc;
    bit v;
    bit hs;
    model();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tests++;
    if ({busy, done, err, cores_reset} !== 4'b1001) begin
      fails++;
      $display("FAIL %s_start busy/done/err/cores_reset got %b exp 1001", name,
               {busy, done, err, cores_reset});
    end
    pos = 0;
    cyc = 0;
    while (pos < m_consumed && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? stream[pos] : 16'($urandom);
      start        = (start_at >= 0) && (pos == start_at);
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s_ready pos %0d got %b exp 1", name, pos, bus.in_ready);
      end
      hs = v && (bus.in_ready === 1'b1);
      @(negedge clk);
      cyc++;
      tests++;
      if (hs && pos >= 1 && pos <= m_wdata.size()) begin
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'(pos - 1), m_wdata[pos - 1]}) begin
          fails++;
          $display("FAIL %s_write pos %0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                   name, pos, bus.mem_we, bus.mem_addr, bus.mem_wdata, pos - 1, m_wdata[pos - 1]);
        end
      end else if (bus.mem_we !== 1'b0) begin
        fails++;
        $display("FAIL %s_nowrite pos %0d got we=%b exp 0", name, pos, bus.mem_we);
      end
      if (hs) pos++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (pos < m_consumed) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout consumed %0d exp %0d", name, pos, m_consumed);
    end
    // {preset, cores_reset, busy, done, err, in_ready, mem_we}
    if (m_ok) begin
      for (int i = 0; i < int'(P); i++) begin
        tests++;
        if ({cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we} !== 7'b1110000) begin
          fails++;
          $display("FAIL %s_preset cyc %0d got %b exp 1110000", name, i,
                   {cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we});
        end
        @(negedge clk);
      end
      tests++;
      if ({cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we} !== 7'b0001000) begin
        fails++;
        $display("FAIL %s_run got %b exp 0001000", name,
                 {cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we});
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if ({cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we} !== 7'b0100100) begin
          fails++;
          $display("FAIL %s_error cyc %0d got %b exp 0100100", name, i,
                   {cores_preset, cores_reset, busy, done, err, bus.in_ready, bus.mem_we});
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({bus.in_ready, bus.mem_we, cores_reset, cores_preset, busy, done, err} !== 7'b0010000) begin
        fails++;
        $display("FAIL reset_ctrl got %b exp 0010000",
                 {bus.in_ready, bus.mem_we, cores_reset, cores_preset, busy, done, err});
      end
      tests++;
      if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
        fails++;
        $display("FAIL reset_bus got addr=%h data=%h exp 0", bus.mem_addr, bus.mem_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic set_nominal(input logic [15:0] csum);
    stream = '{16'd3, 16'h0005, 16'h4000, 16'h8003, csum};
  endtask

  task automatic test_nominal();
    set_nominal(16'hC008);
    run_session(0, -1, "nominal");
  endtask

  task automatic test_bad_csum();
    set_nominal(16'hC009);
    run_session(0, -1, "bad_csum");
  endtask

  task automatic test_len_bounds();
    stream = '{16'd0, 16'h0005, 16'h0005};
    run_session(0, -1, "len0");
    stream = '{16'd65};
    run_session(0, -1, "len65");
    stream.delete();
    stream.push_back(16'd64);
    for (int i = 0; i < 64; i++) stream.push_back(16'(i));
    stream.push_back(16'h07E0);
    run_session(0, -1, "len64");
  endtask

  task automatic test_throttled();
    set_nominal(16'hC008);
    run_session(1, -1, "throttled");
  endtask

  task automatic test_mid_reset();
    set_nominal(16'hC008);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = stream[i];
      @(negedge clk);
    end
    tests++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'd1, 16'h4000}) begin
      fails++;
      $display("FAIL midreset_write got we=%b addr=%0d data=%h exp we=1 addr=1 data=4000",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b1;
    start = 1'b1;
    bus.in_data = stream[3];
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.in_ready, bus.mem_we, cores_reset, cores_preset, busy, done, err} !== 7'b0010000) begin
      fails++;
      $display("FAIL midreset_state got %b exp 0010000",
               {bus.in_ready, bus.mem_we, cores_reset, cores_preset, busy, done, err});
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
      fails++;
      $display("FAIL midreset_bus got addr=%h data=%h exp 0", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_start_ignored();
    set_nominal(16'hC008);
    run_session(0, 2, "start_in_data");
  endtask

  task automatic test_restart();
    set_nominal(16'hC008);
    run_session(1, -1, "restart");
  endtask

  task automatic test_csum_wrap();
    stream = '{16'd2, 16'hFFFF, 16'h0002, 16'h0001};
    run_session(0, -1, "csum_wrap");
  endtask

  task automatic test_random();
    int l;
    int sum;
    for (int s = 0; s < 10; s++) begin
      stream.delete();
      if ($urandom_range(0, 5) == 0) begin
        stream.push_back($urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(65, 65535)));
      end else begin
        l = ($urandom_range(0, 4) == 0) ? int'(DEPTH) : int'($urandom_range(1, 24));
        sum = 0;
        stream.push_back(16'(l));
        for (int i = 0; i < l; i++) begin
          stream.push_back(16'($urandom));
          sum = (sum + int'(stream[i + 1])) % 65536;
        end
        if ($urandom_range(0, 3) == 0) sum = (sum + 1) % 65536;
        stream.push_back(16'(sum));
      end
      run_session(int'($urandom_range(0, 2)),
                  $urandom_range(0, 1) ? -1 : int'($urandom_range(0, stream.size() - 1)),
                  "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_csum();
    test_len_bounds();
    test_throttled();
    test_mid_reset();
    test_start_ignored();
    test_restart();
    test_csum_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
